// File: rtl/reg_file_pkg.sv
// Shared widths, types and the byte-merge used by both the write path and the
// read bypass, so stored and forwarded values can never disagree.
package reg_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  function automatic data_t byte_merge(input data_t old_val, input data_t new_val,
                                       input strb_t strb);
    data_t r;
    r = old_val;
    for (int b = 0; b < STRB_WIDTH; b++)
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bundle of the register file: two read ports, two
// retire lanes and the reservation port.
interface reg_file_mp_if;
  import reg_file_pkg::*;

  addr_t                 raddr1, raddr2;
  data_t                 rdata1, rdata2;
  logic                  rbusy1, rbusy2;
  logic                  wen1, wen2;
  addr_t                 waddr1, waddr2;
  strb_t                 wstrb1, wstrb2;
  data_t                 wdata1, wdata2;
  logic                  resv_en;
  addr_t                 resv_addr;
  logic [ADDR_WIDTH:0]   busy_cnt;

  modport master (
    output raddr1, raddr2, wen1, wen2, waddr1, waddr2, wstrb1, wstrb2,
           wdata1, wdata2, resv_en, resv_addr,
    input  rdata1, rdata2, rbusy1, rbusy2, busy_cnt
  );

  modport slave (
    input  raddr1, raddr2, wen1, wen2, waddr1, waddr2, wstrb1, wstrb2,
           wdata1, wdata2, resv_en, resv_addr,
    output rdata1, rdata2, rbusy1, rbusy2, busy_cnt
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits for in-flight producers, their population count and
// the bypassed busy lookup for both read ports.
module reg_file_scoreboard #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] waddr1,
  input  logic                  wen2,
  input  logic [ADDR_WIDTH-1:0] waddr2,
  input  logic                  resv_en,
  input  logic [ADDR_WIDTH-1:0] resv_addr,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  output logic [ADDR_WIDTH:0]   busy_cnt
);
  localparam int NUM = 2**ADDR_WIDTH;

  logic [NUM-1:0]      busy, busy_nxt;
  logic [ADDR_WIDTH:0] cnt_nxt;

  // A new reservation supersedes a retiring producer on the same index.
  always_comb begin
    busy_nxt = busy;
    if (wen1)    busy_nxt[waddr1]    = 1'b0;
    if (wen2)    busy_nxt[waddr2]    = 1'b0;
    if (resv_en) busy_nxt[resv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NUM; i++)
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign rbusy1 = busy[raddr1] & ~((wen1 && waddr1 == raddr1) || (wen2 && waddr2 == raddr1));
  assign rbusy2 = busy[raddr2] & ~((wen1 && waddr1 == raddr2) || (wen2 && waddr2 == raddr2));
endmodule

// File: rtl/reg_file_mp.sv
// Two-write, two-read register file with byte strobes, write-to-read bypass
// and a busy scoreboard. Widths are configured through reg_file_pkg.
module reg_file_mp #(
  parameter  int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter  int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
  localparam int NUM        = 2**ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);
  import reg_file_pkg::*;

  logic [NUM-1:0][DATA_WIDTH-1:0] mem;
  logic [DATA_WIDTH-1:0]          lane1_val, lane2_base, lane2_val;

  // Lane 2 builds on lane 1's result when both hit one index, so the final
  // store carries the byte union with lane 2 winning overlaps.
  assign lane1_val  = byte_merge(mem[bus.waddr1], bus.wdata1, bus.wstrb1);
  assign lane2_base = (bus.wen1 && bus.waddr1 == bus.waddr2) ? lane1_val : mem[bus.waddr2];
  assign lane2_val  = byte_merge(lane2_base, bus.wdata2, bus.wstrb2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      if (bus.wen1 && bus.waddr1 != '0) mem[bus.waddr1] <= lane1_val;
      if (bus.wen2 && bus.waddr2 != '0) mem[bus.waddr2] <= lane2_val;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] bypass(input logic [ADDR_WIDTH-1:0] ra);
    logic [DATA_WIDTH-1:0] v;
    v = mem[ra];
    if (bus.wen1 && bus.waddr1 == ra) v = byte_merge(v, bus.wdata1, bus.wstrb1);
    if (bus.wen2 && bus.waddr2 == ra) v = byte_merge(v, bus.wdata2, bus.wstrb2);
    if (ra == '0) v = '0;
    return v;
  endfunction

  // Reset also masks the bypass so reads show zero while it is held.
  assign bus.rdata1 = rst ? '0 : bypass(bus.raddr1);
  assign bus.rdata2 = rst ? '0 : bypass(bus.raddr2);

  reg_file_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wen1      (bus.wen1),
    .waddr1    (bus.waddr1),
    .wen2      (bus.wen2),
    .waddr2    (bus.waddr2),
    .resv_en   (bus.resv_en),
    .resv_addr (bus.resv_addr),
    .raddr1    (bus.raddr1),
    .raddr2    (bus.raddr2),
    .rbusy1    (bus.rbusy1),
    .rbusy2    (bus.rbusy2),
    .busy_cnt  (bus.busy_cnt)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a byte-level array model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  reg_file_mp_if bus();
  reg_file_mp dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [32];
  bit          m_busy[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural state after each edge, straight from the rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (bus.wen1 && bus.waddr1 != 0)
        for (int b = 0; b < 4; b++)
          if (bus.wstrb1[b]) m_mem[bus.waddr1][8*b +: 8] = bus.wdata1[8*b +: 8];
      if (bus.wen2 && bus.waddr2 != 0)
        for (int b = 0; b < 4; b++)
          if (bus.wstrb2[b]) m_mem[bus.waddr2][8*b +: 8] = bus.wdata2[8*b +: 8];
      if (bus.wen1) m_busy[bus.waddr1] = 1'b0;
      if (bus.wen2) m_busy[bus.waddr2] = 1'b0;
      if (bus.resv_en && bus.resv_addr != 0) m_busy[bus.resv_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    logic [31:0] v;
    if (rst || ra == 0) return '0;
    v = m_mem[ra];
    for (int b = 0; b < 4; b++) begin
      if (bus.wen1 && bus.waddr1 == ra && bus.wstrb1[b]) v[8*b +: 8] = bus.wdata1[8*b +: 8];
      if (bus.wen2 && bus.waddr2 == ra && bus.wstrb2[b]) v[8*b +: 8] = bus.wdata2[8*b +: 8];
    end
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
    if (rst) return 1'b0;
    return m_busy[ra] && !((bus.wen1 && bus.waddr1 == ra) || (bus.wen2 && bus.waddr2 == ra));
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  always @(negedge clk) begin
    check("rdata1", bus.rdata1, exp_rd(bus.raddr1));
    check("rdata2", bus.rdata2, exp_rd(bus.raddr2));
    check("rbusy1", bus.rbusy1, exp_busy(bus.raddr1));
    check("rbusy2", bus.rbusy2, exp_busy(bus.raddr2));
    check("busy_cnt", bus.busy_cnt, exp_cnt());
  end

  task automatic idle();
    bus.wen1 = 0; bus.waddr1 = 0; bus.wstrb1 = 0; bus.wdata1 = 0;
    bus.wen2 = 0; bus.waddr2 = 0; bus.wstrb2 = 0; bus.wdata2 = 0;
    bus.resv_en = 0; bus.resv_addr = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.wen1 = 1; bus.waddr1 = a; bus.wdata1 = d; bus.wstrb1 = s;
  endtask

  task automatic wr2(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.wen2 = 1; bus.waddr2 = a; bus.wdata2 = d; bus.wstrb2 = s;
  endtask

  initial begin
    idle(); bus.raddr1 = 0; bus.raddr2 = 0;
    repeat (2) step();
    check("rst_cnt", bus.busy_cnt, 0);
    check("rst_rd", bus.rdata1, 0);
    rst = 0;

    // bypass and storage of a full write; r0 stays zero
    wr1(5, 32'hDEADBEEF, 4'hF); bus.raddr1 = 5; #1;
    check("byp_r5", bus.rdata1, 32'hDEADBEEF);
    step(); idle(); #1;
    check("st_r5", bus.rdata1, 32'hDEADBEEF);
    wr1(0, 32'hFFFFFFFF, 4'hF); bus.raddr2 = 0; #1;
    check("byp_r0", bus.rdata2, 0);
    step(); idle(); #1;
    check("st_r0", bus.rdata2, 0);

    // same-address dual write with overlapping strobes
    wr1(7, 32'h11223344, 4'hF); step();
    wr1(7, 32'hAAAAAAAA, 4'h3); wr2(7, 32'hBBBBBBBB, 4'h6); bus.raddr1 = 7; #1;
    check("byp_dual", bus.rdata1, 32'h11BBBBAA);
    step(); idle(); #1;
    check("st_dual", bus.rdata1, 32'h11BBBBAA);

    // reserve, then retire with empty strobe
    wr1(9, 32'h12345678, 4'hF); step(); idle();
    bus.resv_en = 1; bus.resv_addr = 9; step(); idle();
    bus.raddr1 = 9; #1;
    check("resv_busy", bus.rbusy1, 1);
    check("resv_cnt1", bus.busy_cnt, 1);
    wr1(9, 32'hFFFFFFFF, 4'h0); #1;
    check("retire_byp_busy", bus.rbusy1, 0);
    check("retire_keep", bus.rdata1, 32'h12345678);
    check("retire_cnt_hold", bus.busy_cnt, 1);
    step(); idle(); #1;
    check("retire_cnt0", bus.busy_cnt, 0);
    check("retire_data", bus.rdata1, 32'h12345678);

    // reservation and write to the same index in one cycle
    bus.resv_en = 1; bus.resv_addr = 3; wr2(3, 32'hCAFEF00D, 4'hF);
    step(); idle(); bus.raddr1 = 3; #1;
    check("rw_data", bus.rdata1, 32'hCAFEF00D);
    check("rw_busy", bus.rbusy1, 1);
    check("rw_cnt", bus.busy_cnt, 1);
    wr1(3, 0, 4'h0); step(); idle(); #1;
    check("rw_clear", bus.busy_cnt, 0);

    // fill the scoreboard, then retire two in one cycle
    for (int i = 1; i < 32; i++) begin
      bus.resv_en = 1; bus.resv_addr = 5'(i); step();
    end
    idle(); #1;
    check("full_cnt", bus.busy_cnt, 31);
    wr1(1, 0, 4'h0); wr2(2, 0, 4'h0); step(); idle(); #1;
    check("dual_retire", bus.busy_cnt, 29);

    // randomized traffic, occasional async reset
    for (int c = 0; c < 600; c++) begin
      logic [4:0] pool;
      pool = 5'($urandom_range(0, 7));
      bus.wen1 = 1'($urandom_range(0, 1));
      bus.waddr1 = $urandom_range(0, 1) ? pool : 5'($urandom_range(0, 31));
      bus.wstrb1 = 4'($urandom_range(0, 15)); bus.wdata1 = $urandom;
      bus.wen2 = 1'($urandom_range(0, 1));
      bus.waddr2 = $urandom_range(0, 1) ? pool : 5'($urandom_range(0, 31));
      bus.wstrb2 = 4'($urandom_range(0, 15)); bus.wdata2 = $urandom;
      bus.resv_en = 1'($urandom_range(0, 1));
      bus.resv_addr = $urandom_range(0, 1) ? pool : 5'($urandom_range(0, 31));
      bus.raddr1 = $urandom_range(0, 1) ? bus.waddr1 : 5'($urandom_range(0, 31));
      bus.raddr2 = $urandom_range(0, 1) ? bus.waddr2 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        #4 rst = 1;
        @(posedge clk); #1 rst = 0;
      end else begin
        step();
      end
    end

    // reset with a dirty array and pending requests
    wr1(4, $urandom, 4'hF); bus.resv_en = 1; bus.resv_addr = 6;
    #1 rst = 1; #1;
    check("arst_cnt", bus.busy_cnt, 0);
    for (int i = 0; i < 16; i++) begin
      bus.raddr1 = 5'(2*i); bus.raddr2 = 5'(2*i + 1); #1;
      check("arst_rd1", bus.rdata1, 0);
      check("arst_rd2", bus.rdata2, 0);
      check("arst_busy", {bus.rbusy1, bus.rbusy2}, 0);
    end
    step(); rst = 0; idle(); bus.raddr1 = 4; bus.raddr2 = 6; step(); #1;
    check("arst_drop_wr", bus.rdata1, 0);
    check("arst_drop_resv", bus.busy_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file: the next generation of the single-write, two-read file used by the CPU datapath. It adds a second write port, per-byte write strobes, write-to-read bypass, reset that clears the whole array, and a per-register busy scoreboard for in-flight producers. It sits between decode (read/reserve) and writeback (two retire lanes).

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, register index width.
- NUM, 2**ADDR_WIDTH, register count (derived; do not override).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- raddr1, raddr2  in  ADDR_WIDTH  read indices.
- rdata1, rdata2  out  DATA_WIDTH  read data (combinational, bypassed).
- rbusy1, rbusy2  out  1  indexed register still awaits a producer.
- wen1, wen2  in  1  write enables (lane 1 older, lane 2 younger).
- waddr1, waddr2  in  ADDR_WIDTH  write indices.
- wstrb1, wstrb2  in  DATA_WIDTH/8  byte enables.
- wdata1, wdata2  in  DATA_WIDTH  write data.
- resv_en  in  1  mark resv_addr busy.
- resv_addr  in  ADDR_WIDTH  register to reserve.
- busy_cnt  out  ADDR_WIDTH+1  count of busy registers (registered).

## Operation
- Register 0: reads 0, writes and reservations ignored, never busy.
- Write: at posedge, each enabled lane updates only the bytes with strobe set; wstrb all-zero leaves data unchanged.
- Same-address dual write: per byte, lane 2 wins where both strobes set; otherwise union of bytes.
- Read: rdata = stored value, then lane-1 bytes, then lane-2 bytes merged in for any enabled lane whose waddr equals raddr (same precedence as write). Exact same value the array holds after the edge.
- Scoreboard: busy[i] set at posedge by resv_en with resv_addr==i; cleared at posedge by any enabled write to i (regardless of strobe).
- Reserve and write to the same index in one cycle: busy ends set (new producer supersedes retiring one); data still written.
- rbusyN = busy[raddrN] AND NOT (enabled write to raddrN this cycle); unaffected by same-cycle resv.
- busy_cnt tracks population of busy[], updated with it; range 0..NUM-1.

## Timing
- Reset (async assert): every register 0, busy[] 0, busy_cnt 0; hence rdata 0, rbusy 0 immediately. Deassertion synchronous to clk externally.
- Reset mid-operation discards pending writes and reservations of that cycle.
- Write latency: 0 cycles via bypass, 1 cycle in storage.
- Reservation latency: rbusy/busy_cnt reflect it from the next cycle.
- No handshake; every enabled request is accepted every cycle.
- Net busy_cnt change per cycle in {-2..+1}; must never wrap.

## Structure
- Package reg_file_pkg: DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH = DATA_WIDTH/8, byte-merge function (old, new, strobe) shared by write path and bypass.
- Sub-module reg_file_scoreboard: busy[] vector, set/clear priority, busy_cnt, rbusy lookup. Storage, merge and bypass stay in top level.

## Test plan
- Reset with array dirty -> all 32 reads 0, rbusy 0, busy_cnt 0, asynchronously before next edge.
- wen1 r5 0xDEADBEEF strb 0xF, raddr1=5 same cycle -> rdata1 0xDEADBEEF combinationally and after edge; write r0 -> reads 0.
- r7=0x11223344; same cycle wen1 r7 0xAAAAAAAA strb 0x3, wen2 r7 0xBBBBBBBB strb 0x6 -> r7 = 0x11BBBBAA, bypassed read matches.
- resv r9, next cycle rbusy 1 busy_cnt 1; write r9 with strb 0 -> data unchanged, rbusy 0 same cycle, busy_cnt 0 next.
- resv r3 and wen2 r3 same cycle -> r3 updated, busy[3] stays 1, busy_cnt 1.
- Reserve r1..r31 over 31 cycles -> busy_cnt 31; retire r1 and r2 in one cycle -> 29, no wrap.
